// File: rtl/ripple_adder_seq_if.sv
// ----------------------------------------------------------------------------
// ripple_adder_seq_if
//   Operand / result handshake bundle for ripple_adder_seq.
//
//   Operand side : in_valid, in_ready, A, B, ci
//   Result side  : out_valid, out_ready, SUM, co (+ ovf)
//
//   Modports
//     master : the environment (drives operands, accepts results)
//     slave  : the adder sequencer
//
//   Optional feature macro: RIPPLE_ADDER_SEQ_OVF_EN adds the ovf signal.
// ----------------------------------------------------------------------------
interface ripple_adder_seq_if #(
    parameter int N = 12
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         ci;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] SUM;
    logic         co;
`ifdef RIPPLE_ADDER_SEQ_OVF_EN
    logic         ovf;

    modport master (
        output in_valid, A, B, ci, out_ready,
        input  in_ready, out_valid, SUM, co, ovf
    );
    modport slave (
        input  in_valid, A, B, ci, out_ready,
        output in_ready, out_valid, SUM, co, ovf
    );
`else
    modport master (
        output in_valid, A, B, ci, out_ready,
        input  in_ready, out_valid, SUM, co
    );
    modport slave (
        input  in_valid, A, B, ci, out_ready,
        output in_ready, out_valid, SUM, co
    );
`endif
endinterface

// File: rtl/ripple_adder_seq.sv
// ----------------------------------------------------------------------------
// ripple_adder_seq
//   Adds two N-bit operands one 4-bit slice per clock through a single 4-bit
//   ripple datapath and a registered inter-slice carry. Operands are taken on
//   a valid/ready handshake, the result is offered on a valid/ready handshake.
//
//   Ports
//     CK   : clock, all state changes on the rising edge
//     RN   : synchronous active-low reset
//     bus  : ripple_adder_seq_if.slave
//              in_valid / in_ready / A / B / ci    operand handshake
//              out_valid / out_ready / SUM / co    result handshake
//              ovf                                 signed overflow (optional)
//
//   Parameter
//     N    : operand/result width, multiple of 4, at least 4
//
//   Optional feature macro: RIPPLE_ADDER_SEQ_OVF_EN
//     Adds a registered signed-overflow flag computed on the last slice.
// ----------------------------------------------------------------------------
module ripple_adder_seq #(
    parameter int N = 12
) (
    input  logic              CK,
    input  logic              RN,
    ripple_adder_seq_if.slave bus
);

    localparam int NSL = N / 4;
    localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(NSL - 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic           r_c;
    logic [KW-1:0]  r_k;
    logic [N-1:0]   r_sum;

    logic [KW+1:0]  w_base;
    logic [3:0]     w_a_sl;
    logic [3:0]     w_b_sl;
    logic [4:0]     w_sl;
    logic           w_last;

    // ------------------------------------------------------------------------
    // Shared slice datapath: the slice counter picks which nibble of the
    // captured operands is added this cycle.
    // ------------------------------------------------------------------------
    assign w_base = {r_k, 2'b00};
    assign w_a_sl = r_a[w_base +: 4];
    assign w_b_sl = r_b[w_base +: 4];
    assign w_sl   = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {4'b0000, r_c};
    assign w_last = (r_k == K_LAST);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge CK) begin
        if (!RN) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)  w_state_nxt = S_CALC;
            S_CALC:  if (w_last)        w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs, decoded from the state register only so that no input
    // reaches a handshake output combinationally.
    // ------------------------------------------------------------------------
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            S_IDLE:  bus.in_ready  = 1'b1;
            S_DONE:  bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CK) begin
        if (!RN) begin
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= 1'b0;
            r_k   <= '0;
            r_sum <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Operands are sampled only here; later input changes
                    // have no effect on the operation in flight.
                    if (bus.in_valid) begin
                        r_a <= bus.A;
                        r_b <= bus.B;
                        r_c <= bus.ci;
                        r_k <= '0;
                    end
                end
                S_CALC: begin
                    r_sum[w_base +: 4] <= w_sl[3:0];
                    r_c                <= w_sl[4];
                    if (!w_last) r_k <= r_k + K_ONE;
                end
                default: ;
            endcase
        end
    end

    // SUM/co are straight register outputs and so stay put through DONE.
    assign bus.SUM = r_sum;
    assign bus.co  = r_c;

`ifdef RIPPLE_ADDER_SEQ_OVF_EN
    // ------------------------------------------------------------------------
    // Signed overflow = carry into MSB xor carry out of MSB. The carry into
    // the slice's top bit is recovered from its sum bit: s3 = a3 ^ b3 ^ c3.
    // ------------------------------------------------------------------------
    logic r_ovf;
    logic w_cin_msb;

    assign w_cin_msb = w_a_sl[3] ^ w_b_sl[3] ^ w_sl[3];

    always_ff @(posedge CK) begin
        if (!RN) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_CALC && w_last) begin
            r_ovf <= w_cin_msb ^ w_sl[4];
        end
    end

    assign bus.ovf = r_ovf;
`endif

endmodule

// File: doc/ripple_adder_seq.md
# ripple_adder_seq

Multi-cycle sequencer that adds two N-bit operands one 4-bit slice per clock, reusing a single 4-bit ripple-adder datapath and a registered inter-slice carry. It sits directly upstream of the 12-bit ripple-adder consumers. It is a low-area alternative to instantiating three 4-bit ripple adders in parallel. Operands arrive over a valid/ready handshake and results leave over a valid/ready handshake.

## Interface
- N, 12, operand/result width; must be a multiple of 4 and at least 4.
- CK  in  1  clock; all state updates on its rising edge.
- RN  in  1  reset; synchronous and active-low.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept an operand bundle.
- A  in  N  operand A.
- B  in  N  operand B.
- ci  in  1  carry-in.
- out_valid  out  1  SUM/co valid.
- out_ready  in  1  consumer accepts the result.
- SUM  out  N  registered sum.
- co  out  1  registered carry-out of the MSB slice.
- ovf  out  1  signed overflow; present only with RIPPLE_ADDER_SEQ_OVF_EN.

## Operation
- Internal state:
  - FSM with states IDLE, CALC, DONE.
  - Operand registers a_q and b_q, each N bits.
  - Carry register c_q.
  - Slice counter k with range 0..N/4-1, width clog2(N/4), minimum 1 bit.
  - Result register sum_q.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1: capture A→a_q, B→b_q, ci→c_q; set k=0; go to CALC.
- CALC:
  - in_ready=0, out_valid=0.
  - Each cycle compute {c,s} = a_q[4k+3:4k] + b_q[4k+3:4k] + c_q as 5-bit unsigned.
  - Write sum_q[4k+3:4k]=s and c_q=c.
  - If k=N/4-1: go to DONE. Otherwise k=k+1.
- DONE:
  - out_valid=1, in_ready=0.
  - SUM=sum_q, co=c_q; both held stable until the handshake completes.
  - On out_ready=1: go to IDLE.
- Input handshake:
  - A, B and ci are sampled only on the in_valid && in_ready edge.
  - Changes to them at any other time are ignored.
- Output handshake:
  - out_valid must not drop until out_ready is seen.
  - out_ready while out_valid=0 has no effect.
- Arithmetic:
  - Result is exactly (A+B+ci) mod 2^N, with co = bit N.
  - The slice carry chain is identical to three chained 4-bit ripple adders.
- Reset, when RN=0 at a CK edge:
  - State goes to IDLE, k=0, c_q=0, sum_q=0, a_q=b_q=0.
  - Outputs after reset: in_ready=1, out_valid=0, SUM=0, co=0, ovf=0.
  - Reset mid-CALC or mid-DONE discards the operation; no partial result is ever presented.
- No x/z propagation from an unused operand into outputs; all registers have reset values.

## Timing
- Accepting edge is E0. Slices are processed on edges E1..E(N/4).
- out_valid rises after E(N/4). For N=12 that is 3 cycles after acceptance.
- Minimum period between accepts is N/4+2 cycles (4+1 with zero-wait consumer for N=12):
  - accept edge, then N/4 compute edges, then the output handshake edge.
  - in_ready returns 1 the cycle after the output handshake.
- No combinational paths from any input to any output.
- in_ready and out_valid are decoded from the FSM state register only.

## Configuration
- RIPPLE_ADDER_SEQ_OVF_EN defined:
  - Adds output ovf.
  - ovf is registered at the last CALC slice as carry_into_MSB XOR carry_out_of_MSB.
  - ovf is valid with out_valid, cleared by reset, held through DONE.
- RIPPLE_ADDER_SEQ_OVF_EN undefined: no ovf port and no overflow logic; all other behaviour is identical.

## Test plan
- Reset while CALC: RN=0 for one edge at k=1 → next cycle in_ready=1, out_valid=0, SUM=0x000, co=0.
- N=12, A=0xFFF, B=0x001, ci=0, out_ready=1 → out_valid high 3 cycles after accept; SUM=0x000, co=1; with macro ovf=0.
- A=0x7FF, B=0x001, ci=0 → SUM=0x800, co=0; with macro ovf=1.
- A=0x0F0, B=0x00F, ci=1 → SUM=0x100, co=0. This checks carry ripple across the slice 0→1 boundary.
- Backpressure: out_ready=0 for 5 cycles after out_valid.
  - SUM/co stay stable and in_ready=0.
  - A new in_valid with A=0x123 during this window is ignored.
  - After out_ready=1, the next accept occurs no earlier than the following cycle.
- Operand change after accept: A, B toggled every cycle during CALC → result matches the captured operands only.
